// File: rtl/zynq_pl2ps_packet_arbiter.sv
// zynq_pl2ps_packet_arbiter: round-robin packet arbiter sharing one PL-to-PS FIFO lane.
// Each grant emits one header word, then the requester's body words without interleaving.
module zynq_pl2ps_packet_arbiter #(
  parameter int num_req_p = 4,
  parameter int data_width_p = 32,
  parameter int max_len_p = 16
) (
  input  logic                              aclk,
  input  logic                              aresetn,
  input  logic [num_req_p-1:0]              req_v_i,
  input  logic [num_req_p*8-1:0]            req_len_i,
  input  logic [num_req_p*data_width_p-1:0] req_data_i,
  output logic [num_req_p-1:0]              req_yumi_o,
  output logic [data_width_p-1:0]           fifo_data_o,
  output logic                              fifo_v_o,
  input  logic                              fifo_ready_i,
  output logic                              busy_o,
  output logic [3:0]                        grant_id_o,
  output logic [31:0]                       pkt_count_o
);
  localparam int sel_w = $clog2(num_req_p);
  typedef enum logic [1:0] {idle_s, header_s, body_s} state_e;
  state_e state_r, state_n;
  logic [3:0] last_r, win;
  logic [4:0] idx;
  logic [7:0] len_r, cnt_r, win_len;
  logic [7:0] len_a [num_req_p];
  logic [data_width_p-1:0] data_a [num_req_p];
  logic [sel_w-1:0] gsel;
  logic [31:0] hdr;
  logic fire, done;
  for (genvar g = 0; g < num_req_p; g++) begin : g_unpack
    assign len_a[g] = req_len_i[g*8 +: 8];
    assign data_a[g] = req_data_i[g*data_width_p +: data_width_p];
  end
  // Scan downwards so the candidate closest after last_r is the one left in win.
  always_comb begin
    win = last_r;
    idx = '0;
    for (int i = num_req_p; i >= 1; i--) begin
      idx = 5'(last_r) + 5'(i);
      idx = idx >= 5'(num_req_p) ? idx - 5'(num_req_p) : idx;
      if (req_v_i[idx[sel_w-1:0]]) win = idx[3:0];
    end
  end
  assign win_len = len_a[win[sel_w-1:0]] > 8'(max_len_p) ? 8'(max_len_p) : len_a[win[sel_w-1:0]];
  assign gsel = grant_id_o[sel_w-1:0];
  assign hdr = {8'hA5, 4'h0, grant_id_o, 8'h00, len_r};
  assign fire = fifo_v_o & fifo_ready_i;
  assign done = fire & (state_r == header_s ? len_r == 8'd0 : cnt_r == 8'd1);
  always_ff @(posedge aclk) state_r <= !aresetn ? idle_s : state_n;
  always_comb begin
    state_n = state_r == idle_s ? (|req_v_i ? header_s : idle_s)
            : done ? idle_s
            : (state_r == header_s & fire) ? body_s : state_r;
  end
  // Outputs are gated by aresetn so nothing leaves the block during the reset cycle.
  always_comb begin
    fifo_v_o = aresetn & (state_r == header_s | (state_r == body_s & req_v_i[gsel]));
    fifo_data_o = !aresetn ? '0
                : state_r == header_s ? data_width_p'(hdr)
                : state_r == body_s ? data_a[gsel] : '0;
    busy_o = state_r != idle_s;
  end
  assign req_yumi_o = (state_r == body_s & fire) ? num_req_p'(1) << gsel : '0;
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      last_r <= 4'(num_req_p - 1);
      grant_id_o <= '0;
      len_r <= '0;
      cnt_r <= '0;
      pkt_count_o <= '0;
    end else begin
      if (state_r == idle_s && |req_v_i) begin
        grant_id_o <= win;
        len_r <= win_len;
      end
      if (fire) cnt_r <= state_r == header_s ? len_r : cnt_r - 8'd1;
      if (done) begin
        last_r <= grant_id_o;
        pkt_count_o <= pkt_count_o + 32'd1;
      end
    end
  end
endmodule
